pds_mgr: RTL and testbench

- Next-generation power-sourcing manager for NUM_PORTS ports, each with its own power class.
- Ports are turned on one at a time: the highest-priority detected port that fits the budget is granted, then a settle window runs before the next grant (staggered inrush).
- When the budget drops below the power in use, low-priority ports are shed one per cycle.
- Sits between the detection/classification front-end and the port power switches, in place of the fixed 15-unit-per-port scheme.

---
 rtl/pds_mgr_pkg.sv | 17 +
 rtl/pds_prio_sel.sv | 42 ++++
 rtl/pds_mgr.sv | 140 ++++++++++++++
 tb/tb_pds_mgr.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pds_mgr_pkg.sv
// Shared types and helpers for the PoE power-sourcing manager.
// Holds the sequencer state encoding and selector tie-break modes.
package pds_mgr_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } pds_state_t;

    localparam logic PICK_MAX_LOW_IDX  = 1'b0;
    localparam logic PICK_MIN_HIGH_IDX = 1'b1;

    function automatic int sum_w(input int pwr_w, input int n);
        return pwr_w + $clog2(n);
    endfunction

endpackage

// File: rtl/pds_prio_sel.sv
// Masked priority selector: arg-max (ties to lowest index) or
// arg-min (ties to highest index) over packed per-port priorities.
module pds_prio_sel
    import pds_mgr_pkg::*;
#(
    parameter int   N      = 16,
    parameter int   PRIO_W = 2,
    parameter logic MODE   = PICK_MAX_LOW_IDX,
    localparam int  IDX_W  = $clog2(N)
) (
    input  logic [N-1:0]        mask,
    input  logic [N*PRIO_W-1:0] prio,
    output logic [IDX_W-1:0]    idx,
    output logic                valid
);

    logic [PRIO_W-1:0] best;
    logic [PRIO_W-1:0] p;
    logic              take;

    // Linear scan: strict '>' keeps the first tie, '<=' keeps the last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        best  = '0;
        p     = '0;
        take  = 1'b0;
        for (int i = 0; i < N; i++) begin
            p = prio[i*PRIO_W +: PRIO_W];
            if (MODE == PICK_MAX_LOW_IDX)
                take = mask[i] && (!valid || (p > best));
            else
                take = mask[i] && (!valid || (p <= best));
            if (take) begin
                valid = 1'b1;
                best  = p;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pds_mgr.sv
// Power-sourcing manager: staggered one-at-a-time port grants within
// a power budget, plus one-per-cycle shedding of low-priority ports.
module pds_mgr
    import pds_mgr_pkg::*;
#(
    parameter int  NUM_PORTS   = 16,
    parameter int  PRIO_W      = 2,
    parameter int  PWR_W       = 8,
    parameter int  SETTLE_CYC  = 8,
    parameter int  STRICT_PRIO = 1,
    localparam int SUM_W       = sum_w(PWR_W, NUM_PORTS),
    localparam int IDX_W       = $clog2(NUM_PORTS),
    localparam int TMR_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SUM_W-1:0]            pwr_bdj,
    input  logic [NUM_PORTS-1:0]        det,
    input  logic [NUM_PORTS*PRIO_W-1:0] prio,
    input  logic [NUM_PORTS*PWR_W-1:0]  pwr_cls,
    input  logic [NUM_PORTS-1:0]        off,
    input  logic                        ports_off,
    output logic [NUM_PORTS-1:0]        on,
    output logic [SUM_W-1:0]            pwr_used,
    output logic                        state,
    output logic                        grant_pulse,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        shed_pulse
);

    localparam int EXT_W = SUM_W + 1;

    pds_state_t           st_q;
    logic [TMR_W-1:0]     timer_q;
    logic [NUM_PORTS-1:0] surv;
    logic [NUM_PORTS-1:0] elig;
    logic [NUM_PORTS-1:0] fit;
    logic [NUM_PORTS-1:0] cand_mask;
    logic [NUM_PORTS-1:0] cand_oh;
    logic [NUM_PORTS-1:0] vic_oh;
    logic [SUM_W-1:0]     used_sum;
    logic [SUM_W-1:0]     next_sum;
    logic [IDX_W-1:0]     cand_idx;
    logic [IDX_W-1:0]     vic_idx;
    logic                 cand_valid;
    logic                 vic_valid;
    logic                 cand_ok;
    logic                 overload;

    assign surv      = on & ~off & det;
    assign elig      = det & ~on & ~off;
    assign cand_mask = (STRICT_PRIO != 0) ? elig : (elig & fit);
    assign cand_oh   = NUM_PORTS'(1) << cand_idx;
    assign vic_oh    = NUM_PORTS'(1) << vic_idx;
    assign overload  = next_sum > pwr_bdj;
    assign cand_ok   = cand_valid && fit[cand_idx];
    assign pwr_used  = used_sum;
    assign state     = st_q;

    // Present usage, post-clear usage, and per-port fit against budget.
    always_comb begin
        used_sum = '0;
        next_sum = '0;
        fit      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (on[i])
                used_sum = used_sum + SUM_W'(pwr_cls[i*PWR_W +: PWR_W]);
            if (surv[i])
                next_sum = next_sum + SUM_W'(pwr_cls[i*PWR_W +: PWR_W]);
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            fit[i] = ({1'b0, next_sum} + EXT_W'(pwr_cls[i*PWR_W +: PWR_W]))
                     <= {1'b0, pwr_bdj};
        end
    end

    pds_prio_sel #(
        .N      (NUM_PORTS),
        .PRIO_W (PRIO_W),
        .MODE   (PICK_MAX_LOW_IDX)
    ) u_cand (
        .mask  (cand_mask),
        .prio  (prio),
        .idx   (cand_idx),
        .valid (cand_valid)
    );

    pds_prio_sel #(
        .N      (NUM_PORTS),
        .PRIO_W (PRIO_W),
        .MODE   (PICK_MIN_HIGH_IDX)
    ) u_vic (
        .mask  (surv),
        .prio  (prio),
        .idx   (vic_idx),
        .valid (vic_valid)
    );

    // Sequencer: global off, clears, shed, then grant/settle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            on          <= '0;
            st_q        <= IDLE;
            timer_q     <= '0;
            grant_idx   <= '0;
            grant_pulse <= 1'b0;
            shed_pulse  <= 1'b0;
        end else if (ports_off) begin
            on          <= '0;
            st_q        <= IDLE;
            timer_q     <= '0;
            grant_pulse <= 1'b0;
            shed_pulse  <= 1'b0;
        end else if (overload && vic_valid) begin
            on          <= surv & ~vic_oh;
            st_q        <= IDLE;
            timer_q     <= '0;
            grant_pulse <= 1'b0;
            shed_pulse  <= 1'b1;
        end else if (st_q == IDLE && cand_ok) begin
            on          <= surv | cand_oh;
            st_q        <= SETTLE;
            timer_q     <= TMR_W'(SETTLE_CYC - 1);
            grant_idx   <= cand_idx;
            grant_pulse <= 1'b1;
            shed_pulse  <= 1'b0;
        end else begin
            on          <= surv;
            grant_pulse <= 1'b0;
            shed_pulse  <= 1'b0;
            if (st_q == SETTLE) begin
                if (timer_q == '0)
                    st_q <= IDLE;
                else
                    timer_q <= timer_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pds_mgr.sv
// Self-checking bench for pds_mgr: strict and first-fit instances
// share stimulus; grants and sheds are scoreboarded through queues.
module tb_pds_mgr;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pwr_bdj;
    logic [3:0]  det;
    logic [7:0]  prio;
    logic [31:0] pwr_cls;
    logic [3:0]  off;
    logic        ports_off;

    logic [3:0]  on0, on1;
    logic [9:0]  used0, used1;
    logic        st0, st1;
    logic        gp0, gp1;
    logic [1:0]  gi0, gi1;
    logic        sp0, sp1;

    int vecs = 0;
    int errs = 0;
    int cyc_cnt = 0;
    int first_cyc = 0;
    int exp_grant[$];
    logic [3:0] exp_shed[$];

    pds_mgr #(
        .NUM_PORTS(N), .PRIO_W(2), .PWR_W(8),
        .SETTLE_CYC(4), .STRICT_PRIO(1)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .pwr_bdj(pwr_bdj), .det(det),
        .prio(prio), .pwr_cls(pwr_cls), .off(off),
        .ports_off(ports_off), .on(on0), .pwr_used(used0),
        .state(st0), .grant_pulse(gp0), .grant_idx(gi0),
        .shed_pulse(sp0)
    );

    pds_mgr #(
        .NUM_PORTS(N), .PRIO_W(2), .PWR_W(8),
        .SETTLE_CYC(4), .STRICT_PRIO(0)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .pwr_bdj(pwr_bdj), .det(det),
        .prio(prio), .pwr_cls(pwr_cls), .off(off),
        .ports_off(ports_off), .on(on1), .pwr_used(used1),
        .state(st1), .grant_pulse(gp1), .grant_idx(gi1),
        .shed_pulse(sp1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Scoreboard: pop expected grant index / post-shed enables on pulses.
    always @(negedge clk) begin
        if (rst_n && gp0) begin
            vecs++;
            if (exp_grant.size() == 0) begin
                errs++;
                $display("FAIL grant_unexpected: got idx=%0d, want none", gi0);
            end else begin
                int e;
                e = exp_grant.pop_front();
                if (int'(gi0) !== e) begin
                    errs++;
                    $display("FAIL grant_idx: got %0d, want %0d", gi0, e);
                end
            end
        end
        if (rst_n && sp0) begin
            vecs++;
            if (exp_shed.size() == 0) begin
                errs++;
                $display("FAIL shed_unexpected: got on=%b, want none", on0);
            end else begin
                logic [3:0] s;
                s = exp_shed.pop_front();
                if (on0 !== s) begin
                    errs++;
                    $display("FAIL shed_on: got %b, want %b", on0, s);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_port(input int i, input logic d,
                            input logic [1:0] p, input logic [7:0] c);
        det[i]           = d;
        prio[i*2 +: 2]   = p;
        pwr_cls[i*8 +: 8] = c;
    endtask

    task automatic clear_inputs();
        pwr_bdj   = '0;
        det       = '0;
        prio      = '0;
        pwr_cls   = '0;
        off       = '0;
        ports_off = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n   = 1'b0;
        pwr_bdj = 10'd100;
        for (int i = 0; i < N; i++) set_port(i, 1'b1, 2'd0, 8'd20);
        for (int i = 0; i < N; i++) exp_grant.push_back(i);
        cyc(2);
        vecs++;
        if (on0 !== 4'b0000 || on1 !== 4'b0000) begin
            errs++;
            $display("FAIL rst_on: got %b/%b, want 0000", on0, on1);
        end
        vecs++;
        if (st0 !== 1'b0 || gi0 !== 2'd0) begin
            errs++;
            $display("FAIL rst_state: got st=%b idx=%0d, want 0/0", st0, gi0);
        end
        vecs++;
        if (gp0 !== 1'b0 || sp0 !== 1'b0) begin
            errs++;
            $display("FAIL rst_pulse: got gp=%b sp=%b, want 0/0", gp0, sp0);
        end
        rst_n = 1'b1;
        cyc(1);
        first_cyc = cyc_cnt;
        vecs++;
        if (gp0 !== 1'b1 || on0 !== 4'b0001 || st0 !== 1'b1) begin
            errs++;
            $display("FAIL first_grant: got gp=%b on=%b st=%b, want 1/0001/1",
                     gp0, on0, st0);
        end
    endtask

    task automatic test_stagger();
        int got;
        int last;
        got  = 1;
        last = first_cyc;
        for (int k = 0; k < 40 && got < 4; k++) begin
            cyc(1);
            if (gp0) begin
                vecs++;
                if (cyc_cnt - last !== 5) begin
                    errs++;
                    $display("FAIL stagger_gap: got %0d, want 5", cyc_cnt - last);
                end
                last = cyc_cnt;
                got++;
            end
        end
        vecs++;
        if (got !== 4) begin
            errs++;
            $display("FAIL stagger_count: got %0d grants, want 4", got);
        end
        cyc(6);
        vecs++;
        if (on0 !== 4'b1111 || used0 !== 10'd80 || st0 !== 1'b0) begin
            errs++;
            $display("FAIL stagger_final: got on=%b used=%0d st=%b, want 1111/80/0",
                     on0, used0, st0);
        end
    endtask

    task automatic test_prio_fit();
        clear_inputs();
        pwr_bdj = 10'd50;
        set_port(3, 1'b1, 2'd3, 8'd40);
        set_port(0, 1'b1, 2'd1, 8'd10);
        set_port(1, 1'b1, 2'd0, 8'd30);
        set_port(2, 1'b0, 2'd0, 8'd10);
        exp_grant.push_back(3);
        exp_grant.push_back(0);
        do_reset();
        cyc(22);
        vecs++;
        if (on0 !== 4'b1001 || used0 !== 10'd50) begin
            errs++;
            $display("FAIL prio_fit: got on=%b used=%0d, want 1001/50", on0, used0);
        end
        vecs++;
        if (on1 !== 4'b1001) begin
            errs++;
            $display("FAIL prio_fit_ff: got on=%b, want 1001", on1);
        end
    endtask

    task automatic test_strict_ff();
        clear_inputs();
        pwr_bdj = 10'd50;
        set_port(3, 1'b1, 2'd3, 8'd60);
        for (int i = 0; i < 3; i++) set_port(i, 1'b1, 2'd0, 8'd10);
        do_reset();
        cyc(22);
        vecs++;
        if (on0 !== 4'b0000 || st0 !== 1'b0) begin
            errs++;
            $display("FAIL strict_block: got on=%b st=%b, want 0000/0", on0, st0);
        end
        vecs++;
        if (on1 !== 4'b0111 || used1 !== 10'd30) begin
            errs++;
            $display("FAIL first_fit: got on=%b used=%0d, want 0111/30", on1, used1);
        end
    endtask

    task automatic test_shed();
        int cnt;
        int c0;
        int c1;
        clear_inputs();
        pwr_bdj = 10'd100;
        for (int i = 0; i < N; i++) set_port(i, 1'b1, 2'(i), 8'd20);
        for (int i = N - 1; i >= 0; i--) exp_grant.push_back(i);
        do_reset();
        cyc(22);
        vecs++;
        if (on0 !== 4'b1111) begin
            errs++;
            $display("FAIL shed_setup: got on=%b, want 1111", on0);
        end
        exp_shed.push_back(4'b1110);
        exp_shed.push_back(4'b1100);
        pwr_bdj = 10'd45;
        cnt = 0;
        c0  = 0;
        c1  = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            if (sp0) begin
                if (cnt == 0) c0 = cyc_cnt;
                else c1 = cyc_cnt;
                cnt++;
            end
        end
        vecs++;
        if (cnt !== 2 || c1 - c0 !== 1) begin
            errs++;
            $display("FAIL shed_pulses: got %0d gap %0d, want 2 gap 1", cnt, c1 - c0);
        end
        vecs++;
        if (on0 !== 4'b1100 || used0 !== 10'd40) begin
            errs++;
            $display("FAIL shed_final: got on=%b used=%0d, want 1100/40", on0, used0);
        end
    endtask

    task automatic test_clears();
        clear_inputs();
        pwr_bdj = 10'd100;
        for (int i = 0; i < N; i++) set_port(i, 1'b1, 2'd0, 8'd20);
        for (int i = 0; i < N; i++) exp_grant.push_back(i);
        do_reset();
        cyc(22);
        off[2] = 1'b1;
        cyc(1);
        vecs++;
        if (on0 !== 4'b1011 || sp0 !== 1'b0) begin
            errs++;
            $display("FAIL off_clear: got on=%b sp=%b, want 1011/0", on0, sp0);
        end
        cyc(8);
        vecs++;
        if (on0 !== 4'b1011) begin
            errs++;
            $display("FAIL off_hold: got on=%b, want 1011", on0);
        end
        exp_grant.push_back(2);
        off[2] = 1'b0;
        cyc(1);
        vecs++;
        if (gp0 !== 1'b1 || on0 !== 4'b1111 || st0 !== 1'b1) begin
            errs++;
            $display("FAIL regrant: got gp=%b on=%b st=%b, want 1/1111/1",
                     gp0, on0, st0);
        end
        ports_off = 1'b1;
        cyc(1);
        vecs++;
        if (on0 !== 4'b0000 || st0 !== 1'b0 || gp0 !== 1'b0 || sp0 !== 1'b0) begin
            errs++;
            $display("FAIL ports_off: got on=%b st=%b gp=%b sp=%b, want 0000/0/0/0",
                     on0, st0, gp0, sp0);
        end
        cyc(3);
        vecs++;
        if (on0 !== 4'b0000 || st0 !== 1'b0) begin
            errs++;
            $display("FAIL ports_off_hold: got on=%b st=%b, want 0000/0", on0, st0);
        end
        for (int i = 0; i < N; i++) exp_grant.push_back(i);
        ports_off = 1'b0;
        cyc(22);
        vecs++;
        if (on0 !== 4'b1111) begin
            errs++;
            $display("FAIL resume: got on=%b, want 1111", on0);
        end
        det[1] = 1'b0;
        cyc(1);
        vecs++;
        if (on0 !== 4'b1101 || sp0 !== 1'b0 || used0 !== 10'd60) begin
            errs++;
            $display("FAIL det_drop: got on=%b sp=%b used=%0d, want 1101/0/60",
                     on0, sp0, used0);
        end
    endtask

    task automatic test_drain();
        cyc(2);
        vecs++;
        if (exp_grant.size() !== 0 || exp_shed.size() !== 0) begin
            errs++;
            $display("FAIL drain: got %0d grants %0d sheds pending, want 0/0",
                     exp_grant.size(), exp_shed.size());
        end
    endtask

    initial begin
        test_reset();
        test_stagger();
        test_prio_fit();
        test_strict_ff();
        test_shed();
        test_clears();
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
